argmax_block: RTL and testbench

- Final stage of the GCN inference pipeline; runs after the combination block finishes.
- Reads the ADJ·FM·WM result matrix one row per cycle through a row-address/row-data interface.
- For each node (row), computes the column index of the largest value and stores it in a per-node result array.
- Asserts done once every row has been classified.

---
 rtl/argmax_block.sv | 97 +++++++++
 tb/tb_argmax_block.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/argmax_block.sv
// Final GCN stage: reads the result matrix one row per cycle and records the
// column index of each row's largest element, then raises done.
module argmax_block #(
   parameter int unsigned FEATURE_ROWS      = 6,
   parameter int unsigned WEIGHT_COLS       = 3,
   parameter int unsigned DOT_PROD_WIDTH    = 16,
   parameter int unsigned MAX_ADDRESS_WIDTH = 2,
   parameter int unsigned FEATURE_WIDTH     = $clog2(FEATURE_ROWS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         done_comb,
   input  logic [DOT_PROD_WIDTH-1:0]    adj_fm_wm_row   [0:WEIGHT_COLS-1],
   output logic [FEATURE_WIDTH-1:0]     read_row,
   output logic                         done,
   output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:FEATURE_ROWS-1]
);

   localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROCESS,
      S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [FEATURE_WIDTH-1:0]     row_counter_q, row_counter_d;
   logic                         done_q, done_d;
   logic [MAX_ADDRESS_WIDTH-1:0] answer_q [0:FEATURE_ROWS-1];
   logic [MAX_ADDRESS_WIDTH-1:0] answer_d [0:FEATURE_ROWS-1];

   logic [DOT_PROD_WIDTH-1:0]    max_val;
   logic [MAX_ADDRESS_WIDTH-1:0] max_column_index;

   // Unsigned scan; strict greater-than keeps the lowest index on ties.
   always_comb begin
      max_val          = adj_fm_wm_row[0];
      max_column_index = '0;
      for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
         if (adj_fm_wm_row[c] > max_val) begin
            max_val          = adj_fm_wm_row[c];
            max_column_index = MAX_ADDRESS_WIDTH'(c);
         end
      end
   end

   // Next-state, row counter and result capture.
   always_comb begin
      state_d       = state_q;
      row_counter_d = row_counter_q;
      answer_d      = answer_q;
      case (state_q)
         S_IDLE: begin
            if (done_comb) begin
               state_d = S_PROCESS;
            end
         end
         S_PROCESS: begin
            answer_d[row_counter_q] = max_column_index;
            if (row_counter_q == LAST_ROW) begin
               row_counter_d = '0;
               state_d       = S_DONE;
            end else begin
               row_counter_d = row_counter_q + FEATURE_WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d       = S_IDLE;
            row_counter_d = '0;
         end
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         row_counter_q <= '0;
         done_q        <= 1'b0;
         answer_q      <= '{default: '0};
      end else begin
         state_q       <= state_d;
         row_counter_q <= row_counter_d;
         done_q        <= done_d;
         answer_q      <= answer_d;
      end
   end

   assign read_row        = row_counter_q;
   assign done            = done_q;
   assign max_addi_answer = answer_q;

endmodule

// File: tb/tb_argmax_block.sv
// Directed self-checking bench for argmax_block: reset, main sequence,
// tie/unsigned rows with a one-cycle done_comb pulse, and mid-run reset.
module tb_argmax_block;

   localparam int unsigned ROWS = 6;
   localparam int unsigned COLS = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        done_comb;
   logic [15:0] adj_fm_wm_row   [0:COLS-1];
   logic [2:0]  read_row;
   logic        done;
   logic [1:0]  max_addi_answer [0:ROWS-1];

   logic [15:0] mem [0:ROWS-1][0:COLS-1];

   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned fails  = 0;

   argmax_block dut (
      .clk             (clk),
      .reset           (reset),
      .done_comb       (done_comb),
      .adj_fm_wm_row   (adj_fm_wm_row),
      .read_row        (read_row),
      .done            (done),
      .max_addi_answer (max_addi_answer)
   );

   always #5 clk = ~clk;

   // Combinational row source, as the combination block would present it.
   always_comb begin
      for (int c = 0; c < COLS; c++) begin
         adj_fm_wm_row[c] = (int'(read_row) < ROWS) ? mem[read_row][c] : 16'h0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ans_packed();
      logic [11:0] r;
      for (int i = 0; i < ROWS; i++) r[11-2*i -: 2] = max_addi_answer[i];
      return r;
   endfunction

   task automatic set_row(input int r, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
      mem[r][0] = a;
      mem[r][1] = b;
      mem[r][2] = c;
   endtask

   task automatic load_main();
      set_row(0, 16'd0,    16'd0,     16'd0);
      set_row(1, 16'd11488, 16'd0,    16'd0);
      set_row(2, 16'd6684, 16'd0,     16'd0);
      set_row(3, 16'd7687, 16'd6093,  16'd0);
      set_row(4, 16'd7687, 16'd9853,  16'd8976);
      set_row(5, 16'd7687, 16'd16537, 16'd17952);
   endtask

   task automatic load_ties();
      set_row(0, 16'd5,    16'd5,    16'd3);
      set_row(1, 16'd1,    16'd9,    16'd9);
      set_row(2, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      set_row(3, 16'h8000, 16'h7FFF, 16'h0000);
      set_row(4, 16'd0,    16'd0,    16'd1);
      set_row(5, 16'd3,    16'd7,    16'd2);
   endtask

   // Expected index per row, entry 0 in the top two bits.
   localparam logic [11:0] EXP_MAIN = {2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
   localparam logic [11:0] EXP_TIES = {2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1};

   initial begin
      bit seen;
      reset     = 1'b1;
      done_comb = 1'b0;
      load_main();

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      #1;
      check("rst_read_row", 32'(read_row), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_answers", 32'(ans_packed()), 32'd0);

      // Idle with done_comb low for ten cycles.
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("idle_done", 32'(done), 32'd0);
      check("idle_read_row", 32'(read_row), 32'd0);

      // Main sequence: sampling edge counts as edge 1, done after edge 7.
      @(negedge clk);
      done_comb = 1'b1;
      @(posedge clk);
      #1;
      check("main_e1_read_row", 32'(read_row), 32'd0);
      check("main_e1_done", 32'(done), 32'd0);
      for (int k = 1; k < ROWS; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("main_read_row_%0d", k), 32'(read_row), 32'(k));
         check($sformatf("main_done_low_%0d", k), 32'(done), 32'd0);
         check($sformatf("main_ans_%0d", k - 1), 32'(max_addi_answer[k-1]),
               32'(EXP_MAIN[11-2*(k-1) -: 2]));
      end
      @(posedge clk);
      #1;
      check("main_done_e7", 32'(done), 32'd1);
      check("main_read_row_done", 32'(read_row), 32'd0);
      check("main_answers", 32'(ans_packed()), 32'(EXP_MAIN));

      // DONE is terminal: done_comb toggling has no effect.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         done_comb = ~done_comb;
      end
      @(posedge clk);
      #1;
      check("done_hold", 32'(done), 32'd1);
      check("done_hold_answers", 32'(ans_packed()), 32'(EXP_MAIN));
      check("done_hold_read_row", 32'(read_row), 32'd0);

      // Ties and unsigned compare, started by a one-cycle done_comb pulse.
      @(negedge clk);
      done_comb = 1'b0;
      reset     = 1'b1;
      load_ties();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      done_comb = 1'b1;
      @(negedge clk);
      done_comb = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("pulse_done_reached", 32'(seen), 32'd1);
      check("ties_answers", 32'(ans_packed()), 32'(EXP_TIES));
      repeat (20) @(posedge clk);
      #1;
      check("pulse_done_stays", 32'(done), 32'd1);
      check("pulse_answers_hold", 32'(ans_packed()), 32'(EXP_TIES));

      // Mid-run reset while row_counter is 3.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      done_comb = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("mid_read_row3", 32'(read_row), 32'd3);
      check("mid_partial", 32'(ans_packed()), 32'({2'd0, 2'd1, 2'd0, 6'd0}));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_read_row", 32'(read_row), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_answers", 32'(ans_packed()), 32'd0);

      // Re-run with main data.
      load_main();
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      check("rerun_done_reached", 32'(seen), 32'd1);
      check("rerun_answers", 32'(ans_packed()), 32'(EXP_MAIN));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
